// File: rtl/ahb_slave_pkg.sv
// Shared types and helpers for the burst-capable AHB-Lite memory slave:
// transfer encodings, response codes, FSM states and byte-lane math.
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WAIT = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_ERR1 = 3'd3;
    localparam state_t ST_ERR2 = 3'd4;

    function automatic int bus_log2(input int data_w);
        return (data_w == 64) ? 3 : 2;
    endfunction

    function automatic logic size_ok(input logic [2:0] hsize, input int data_w);
        return int'(hsize) <= bus_log2(data_w);
    endfunction

    // Little-endian lane mask; oversized transfers select no lanes at all.
    function automatic logic [7:0] lane_mask(input logic [2:0] addr_low,
                                             input logic [2:0] hsize,
                                             input int         data_w);
        int nbytes;
        int mask;
        if (!size_ok(hsize, data_w))
            return 8'h00;
        nbytes = 1 << hsize;
        mask   = ((1 << nbytes) - 1) << addr_low;
        return 8'(mask);
    endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Combinational byte-lane strobe generator: turns the low address bits and
// hsize into a per-lane write enable plus a misalignment flag.
module ahb_byte_strobe
    import ahb_slave_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          addr_low,
    input  logic [2:0]          hsize,
    output logic [DATA_W/8-1:0] strobe,
    output logic                align_err
);

    localparam int BYTE_W = DATA_W / 8;

    always_comb begin
        strobe    = BYTE_W'(lane_mask(addr_low, hsize, DATA_W));
        align_err = 1'b0;
        // Any address bit below the transfer size must be zero.
        for (int b = 0; b < 3; b++) begin
            if ((b < int'(hsize)) && addr_low[b])
                align_err = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_slave_burst.sv
// Memory-backed AHB-Lite slave with programmable NONSEQ wait states,
// zero-wait SEQ beats, BUSY handling, byte-lane writes and two-cycle ERROR.
module ahb_slave_burst
    import ahb_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              slv_busy,
    output logic              hready,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int BYTE_W = DATA_W / 8;
    localparam int LSB    = $clog2(BYTE_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              a_write;
    logic [IDX_W-1:0]  a_index;
    logic [BYTE_W-1:0] a_strobe;

    logic [2:0]        addr_low;
    logic [ADDR_W-1:0] word_idx;
    logic [BYTE_W-1:0] strobe;
    logic              align_err;
    logic              addr_err;
    logic              xfer;

    assign addr_low = 3'(haddr[LSB-1:0]);

    ahb_byte_strobe #(.DATA_W(DATA_W)) u_strobe (
        .addr_low  (addr_low),
        .hsize     (hsize),
        .strobe    (strobe),
        .align_err (align_err)
    );

    always_comb begin
        word_idx = haddr >> LSB;
        addr_err = (32'(word_idx) >= MEM_DEPTH) || !size_ok(hsize, DATA_W) || align_err;
        xfer     = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    end

    // ERR2 ignores slv_busy so the error response always completes in two cycles.
    always_comb begin
        case (state)
            ST_WAIT, ST_ERR1: hready = 1'b0;
            ST_ERR2:          hready = 1'b1;
            default:          hready = !slv_busy;
        endcase
        hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        hrdata = ((state == ST_DATA) && !a_write && !slv_busy) ? mem[a_index] : '0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            a_write  <= 1'b0;
            a_index  <= '0;
            a_strobe <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (!slv_busy) begin
                        if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                            state    <= ST_DATA;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: ;
            endcase

            // Address phase sampling also overrides the state on the edge that finishes a data phase.
            if (hready) begin
                if (xfer) begin
                    a_write  <= hwrite;
                    a_index  <= word_idx[IDX_W-1:0];
                    a_strobe <= strobe;
                    if (addr_err) begin
                        state <= ST_ERR1;
                    end else if ((htrans == HTRANS_NONSEQ) && (WAIT_STATES > 0)) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_DATA;
                    end
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hresetn && (state == ST_DATA) && a_write && !slv_busy) begin
            for (int b = 0; b < BYTE_W; b++) begin
                if (a_strobe[b])
                    mem[a_index][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_burst.sv
// Self-checking bench for ahb_slave_burst: three instances with different
// wait-state/depth settings share one bus; each test watches one instance.
module tb_ahb_slave_burst;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [1:0]  htrans = T_IDLE;
    logic        hwrite = 1'b0;
    logic [7:0]  haddr = 8'h00;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = 32'h0;
    logic        slv_busy = 1'b0;

    logic        rdy0, rdy2, rdy3;
    logic        resp0, resp2, resp3;
    logic [31:0] rd0, rd2, rd3;

    int total = 0;
    int bad = 0;

    always #5 hclk = ~hclk;

    ahb_slave_burst #(.DATA_W(32), .ADDR_W(8), .MEM_DEPTH(16), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans), .hwrite(hwrite), .haddr(haddr),
        .hsize(hsize), .hwdata(hwdata), .slv_busy(slv_busy),
        .hready(rdy0), .hresp(resp0), .hrdata(rd0)
    );

    ahb_slave_burst #(.DATA_W(32), .ADDR_W(8), .MEM_DEPTH(64), .WAIT_STATES(2)) u2 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans), .hwrite(hwrite), .haddr(haddr),
        .hsize(hsize), .hwdata(hwdata), .slv_busy(slv_busy),
        .hready(rdy2), .hresp(resp2), .hrdata(rd2)
    );

    ahb_slave_burst #(.DATA_W(32), .ADDR_W(8), .MEM_DEPTH(64), .WAIT_STATES(3)) u3 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans), .hwrite(hwrite), .haddr(haddr),
        .hsize(hsize), .hwdata(hwdata), .slv_busy(slv_busy),
        .hready(rdy3), .hresp(resp3), .hrdata(rd3)
    );

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [21];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic w, input logic [7:0] a,
                                 input logic [2:0] s, input logic [31:0] d, input logic b);
        htrans   = t;
        hwrite   = w;
        haddr    = a;
        hsize    = s;
        hwdata   = d;
        slv_busy = b;
    endtask

    task automatic nextCycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic resetAll(input string tag);
        applyStimulus(T_IDLE, 1'b0, 8'h00, 3'd2, 32'h0, 1'b0);
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        checkOutput({tag, " reset hready"}, 32'(rdy0), 32'd1);
        checkOutput({tag, " reset hresp"}, 32'(resp0), 32'd0);
        checkOutput({tag, " reset hrdata"}, rd0, 32'h0);
        hresetn = 1'b1;
    endtask

    initial begin
        int    addr_beat;
        int    dbeat;
        int    cycles;
        int    lows;
        logic  done;
        logic  rdy;
        logic  exp_ready [3];
        logic [31:0] exp_rdata [3];

        vecs[0]  = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[1]  = '{T_NONSEQ, 1'b1, 8'h0c, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[2]  = '{T_NONSEQ, 1'b0, 8'h0c, 3'd2, 32'h5a5a5a5a, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{T_NONSEQ, 1'b1, 8'h05, 3'd0, 32'h0,        1'b1, 1'b0, 32'h5a5a5a5a};
        vecs[4]  = '{T_NONSEQ, 1'b0, 8'h04, 3'd2, 32'h0000ab00, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{T_NONSEQ, 1'b1, 8'h06, 3'd1, 32'h0,        1'b1, 1'b0, 32'h1122ab44};
        vecs[6]  = '{T_NONSEQ, 1'b0, 8'h04, 3'd2, 32'hbeef0000, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b1, 1'b0, 32'hbeefab44};
        vecs[8]  = '{T_NONSEQ, 1'b0, 8'hfc, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[9]  = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[10] = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[11] = '{T_NONSEQ, 1'b1, 8'h02, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[12] = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'hdeadbeef, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{T_NONSEQ, 1'b0, 8'h00, 3'd3, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[14] = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[15] = '{T_NONSEQ, 1'b0, 8'h08, 3'd2, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[16] = '{T_SEQ,    1'b0, 8'h0c, 3'd2, 32'h0,        1'b1, 1'b0, 32'h10000002};
        vecs[17] = '{T_BUSY,   1'b0, 8'h10, 3'd2, 32'h0,        1'b1, 1'b0, 32'h5a5a5a5a};
        vecs[18] = '{T_SEQ,    1'b0, 8'h10, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[19] = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b1, 1'b0, 32'h10000004};
        vecs[20] = '{T_IDLE,   1'b0, 8'h00, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0};

        $display("[TB] table-driven pipeline on WAIT_STATES=0, MEM_DEPTH=16");
        resetAll("table");
        for (int i = 0; i < 16; i++)
            u0.mem[i] = 32'h10000000 + 32'(i);
        u0.mem[1] = 32'h11223344;
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].trans, vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0);
            @(negedge hclk);
            checkOutput($sformatf("row%0d hready", i), 32'(rdy0), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("row%0d hresp", i), 32'(resp0), 32'(vecs[i].exp_resp));
            checkOutput($sformatf("row%0d hrdata", i), rd0, vecs[i].exp_rdata);
            nextCycle();
        end
        checkOutput("mem3 after word write", u0.mem[3], 32'h5a5a5a5a);
        checkOutput("mem1 after sub-word writes", u0.mem[1], 32'hbeefab44);
        checkOutput("mem0 untouched by errored write", u0.mem[0], 32'h10000000);

        $display("[TB] NONSEQ read with two wait states");
        resetAll("ws2");
        u2.mem[4] = 32'hffffff00;
        applyStimulus(T_NONSEQ, 1'b0, 8'h10, 3'd2, 32'h0, 1'b0);
        @(negedge hclk);
        checkOutput("ws2 addr hready", 32'(rdy2), 32'd1);
        nextCycle();
        applyStimulus(T_IDLE, 1'b0, 8'h00, 3'd2, 32'h0, 1'b0);
        exp_ready = '{1'b0, 1'b0, 1'b1};
        exp_rdata = '{32'h0, 32'h0, 32'hffffff00};
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            checkOutput($sformatf("ws2 data%0d hready", k), 32'(rdy2), 32'(exp_ready[k]));
            checkOutput($sformatf("ws2 data%0d hrdata", k), rd2, exp_rdata[k]);
            nextCycle();
        end
        @(negedge hclk);
        checkOutput("ws2 hrdata after", rd2, 32'h0);
        nextCycle();

        $display("[TB] NONSEQ + 3 SEQ write burst with three wait states");
        resetAll("burst");
        for (int i = 8; i < 12; i++)
            u3.mem[i] = 32'h0;
        addr_beat = 0;
        dbeat     = -1;
        cycles    = 0;
        lows      = 0;
        done      = 1'b0;
        applyStimulus(T_NONSEQ, 1'b1, 8'h20, 3'd2, 32'h0, 1'b0);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge hclk);
            rdy = rdy3;
            cycles++;
            if (!rdy)
                lows++;
            nextCycle();
            if (rdy) begin
                if (dbeat == 3)
                    done = 1'b1;
                dbeat = addr_beat;
                if (addr_beat >= 0 && addr_beat < 3)
                    addr_beat++;
                else
                    addr_beat = -1;
                hwdata = (dbeat >= 0) ? 32'(dbeat + 1) : 32'h0;
                if (addr_beat >= 0) begin
                    htrans = T_SEQ;
                    haddr  = 8'(32'h20 + 32'(4 * addr_beat));
                end else begin
                    htrans = T_IDLE;
                end
            end
        end
        checkOutput("burst completed in time", 32'(done), 32'd1);
        checkOutput("burst cycle count", 32'(cycles), 32'd8);
        checkOutput("burst wait cycles", 32'(lows), 32'd3);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("burst mem%0d", 8 + i), u3.mem[8 + i], 32'(i + 1));

        $display("[TB] slv_busy stall during a SEQ write");
        resetAll("stall");
        u0.mem[12] = 32'h0;
        u0.mem[13] = 32'h1000000d;
        applyStimulus(T_NONSEQ, 1'b1, 8'h30, 3'd2, 32'h0, 1'b0);
        @(negedge hclk);
        checkOutput("stall nonseq hready", 32'(rdy0), 32'd1);
        nextCycle();
        applyStimulus(T_SEQ, 1'b1, 8'h34, 3'd2, 32'h000000a1, 1'b0);
        @(negedge hclk);
        checkOutput("stall seq hready", 32'(rdy0), 32'd1);
        nextCycle();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(T_IDLE, 1'b0, 8'h00, 3'd2, 32'hbad0bad0, 1'b1);
            @(negedge hclk);
            checkOutput($sformatf("stall%0d hready", k), 32'(rdy0), 32'd0);
            checkOutput($sformatf("stall%0d mem13 held", k), u0.mem[13], 32'h1000000d);
            nextCycle();
        end
        checkOutput("stall mem12 first beat", u0.mem[12], 32'h000000a1);
        applyStimulus(T_IDLE, 1'b0, 8'h00, 3'd2, 32'h000000a2, 1'b0);
        @(negedge hclk);
        checkOutput("stall release hready", 32'(rdy0), 32'd1);
        nextCycle();
        checkOutput("stall mem13 committed", u0.mem[13], 32'h000000a2);

        $display("[TB] reset pulse in the middle of WAIT");
        resetAll("midwait");
        u3.mem[5] = 32'h00000077;
        applyStimulus(T_NONSEQ, 1'b1, 8'h14, 3'd2, 32'h0, 1'b0);
        @(negedge hclk);
        checkOutput("midwait addr hready", 32'(rdy3), 32'd1);
        nextCycle();
        applyStimulus(T_IDLE, 1'b0, 8'h00, 3'd2, 32'h00001234, 1'b0);
        @(negedge hclk);
        checkOutput("midwait wait hready", 32'(rdy3), 32'd0);
        #2;
        hresetn = 1'b0;
        #1;
        checkOutput("midwait in-reset hready", 32'(rdy3), 32'd1);
        checkOutput("midwait in-reset hresp", 32'(resp3), 32'd0);
        checkOutput("midwait in-reset hrdata", rd3, 32'h0);
        nextCycle();
        hresetn = 1'b1;
        repeat (5) nextCycle();
        checkOutput("midwait hready after", 32'(rdy3), 32'd1);
        checkOutput("midwait no write", u3.mem[5], 32'h00000077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
